dcp_print_engine: RTL and testbench

//   Transmit-side responder for the debug control processor's print requests.

---
 rtl/dcp_print_engine.sv | 137 +++++++++++++
 tb/tb_dcp_print_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcp_print_engine.sv
// Print engine for the debug control processor: turns one print request
// (a single character or a 32-bit word as hex text) into ASCII bytes on a
// valid/ready stream towards the UART transmitter.
module dcp_print_engine #(
    parameter bit         HEX_UPPER = 1'b1,
    parameter bit         SEP_EN    = 1'b1,
    parameter logic [7:0] SEP_CHAR  = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_tx,
    input  logic        type_tx,
    input  logic [31:0] dout_tx,
    output logic        ack_tx,
    output logic [7:0]  d_tx,
    output logic        vld_tx,
    input  logic        rdy_tx
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;
    localparam int unsigned BW = 8;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(7);

    typedef enum logic [2:0] {
        IDLE,
        SEND_CHAR,
        SEND_HEX,
        SEND_SEP,
        DONE
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [DW-1:0]   word, word_d;
    logic [BW-1:0]   d_d;
    logic            vld_d;
    logic            ack_d;
    logic            xfer;

    // ASCII encoding of one hex nibble
    function automatic logic [BW-1:0] hex_char(input logic [3:0] n);
        logic [BW-1:0] alpha_base;
        alpha_base = HEX_UPPER ? 8'h41 : 8'h61;
        if (n < 4'd10) begin
            return 8'h30 + BW'(n);
        end
        return alpha_base + BW'(n) - 8'd10;
    endfunction

    assign xfer = vld_tx & rdy_tx;

    // State, digit counter, latched word and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            word   <= '0;
            d_tx   <= '0;
            vld_tx <= 1'b0;
            ack_tx <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            word   <= word_d;
            d_tx   <= d_d;
            vld_tx <= vld_d;
            ack_tx <= ack_d;
        end
    end

    // Next-state and next-output logic; the latched word is rotated so the
    // upcoming digit always sits in word[27:24]
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        word_d  = word;
        d_d     = d_tx;
        vld_d   = vld_tx;
        ack_d   = 1'b0;

        case (state)
            IDLE: begin
                if (req_tx) begin
                    word_d = dout_tx;
                    vld_d  = 1'b1;
                    if (type_tx) begin
                        state_d = SEND_HEX;
                        cnt_d   = '0;
                        d_d     = hex_char(dout_tx[31:28]);
                    end else begin
                        state_d = SEND_CHAR;
                        d_d     = dout_tx[7:0];
                    end
                end
            end
            SEND_CHAR: begin
                if (xfer) begin
                    state_d = DONE;
                    vld_d   = 1'b0;
                    ack_d   = 1'b1;
                end
            end
            SEND_HEX: begin
                if (xfer) begin
                    if (cnt != LAST_DIGIT) begin
                        cnt_d  = cnt + CW'(1);
                        word_d = {word[27:0], word[31:28]};
                        d_d    = hex_char(word[27:24]);
                    end else if (SEP_EN) begin
                        state_d = SEND_SEP;
                        d_d     = SEP_CHAR;
                    end else begin
                        state_d = DONE;
                        vld_d   = 1'b0;
                        ack_d   = 1'b1;
                    end
                end
            end
            SEND_SEP: begin
                if (xfer) begin
                    state_d = DONE;
                    vld_d   = 1'b0;
                    ack_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcp_print_engine.sv
// Bench for dcp_print_engine: two instances (upper-case hex with separator,
// lower-case hex without) share stimulus; each is checked every cycle
// against a request-level model that expands a request into its byte list.
module tb_dcp_print_engine;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        req  = 1'b0;
    logic        typ  = 1'b0;
    logic        rdy  = 1'b1;
    logic [31:0] dout = '0;

    logic       ack_a, vld_a, ack_b, vld_b;
    logic [7:0] d_a, d_b;

    int vectors     = 0;
    int miscompares = 0;

    // model: 0 idle, 1 sending expected bytes, 2 ack cycle
    int         mode    [2];
    int         pos     [2];
    int         len     [2];
    logic [7:0] expq    [2][9];
    int         ack_cnt [2];
    logic [7:0] log_a[$];
    logic [7:0] log_b[$];

    dcp_print_engine #(.HEX_UPPER(1'b1), .SEP_EN(1'b1), .SEP_CHAR(8'h20)) dut_a (
        .clk(clk), .rst(rst), .req_tx(req), .type_tx(typ), .dout_tx(dout),
        .ack_tx(ack_a), .d_tx(d_a), .vld_tx(vld_a), .rdy_tx(rdy)
    );

    dcp_print_engine #(.HEX_UPPER(1'b0), .SEP_EN(1'b0), .SEP_CHAR(8'h20)) dut_b (
        .clk(clk), .rst(rst), .req_tx(req), .type_tx(typ), .dout_tx(dout),
        .ack_tx(ack_b), .d_tx(d_b), .vld_tx(vld_b), .rdy_tx(rdy)
    );

    always #5 clk = ~clk;

    task automatic cmp(input bit ok, input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input int n, input bit up);
        if (n < 10) return 8'(8'h30 + n);
        return 8'((up ? 8'h41 : 8'h61) + n - 10);
    endfunction

    // expand a request into the byte list instance i must emit
    task automatic build(input int i);
        bit up  = (i == 0);
        bit sep = (i == 0);
        if (!typ) begin
            expq[i][0] = dout[7:0];
            len[i] = 1;
        end else begin
            for (int k = 0; k < 8; k++) expq[i][k] = hexc(int'((dout >> (28 - 4 * k)) & 32'hF), up);
            len[i] = 8;
            if (sep) begin
                expq[i][8] = 8'h20;
                len[i] = 9;
            end
        end
        pos[i] = 0;
    endtask

    // per-cycle check of one instance, then advance its model over the coming edge
    task automatic chk(input int i, input logic v, input logic a, input logic [7:0] dd);
        logic [31:0] act;
        act = {22'b0, a, v, dd};
        if (a) ack_cnt[i]++;
        if (v && rdy && !rst) begin
            if (i == 0) log_a.push_back(dd);
            else        log_b.push_back(dd);
        end
        if (rst) begin
            cmp(!v && !a && dd == 8'h00, "reset_state", act, 32'h0);
            mode[i] = 0;
            return;
        end
        case (mode[i])
            0: begin
                cmp(!v && !a, "idle_outputs", act, 32'h0);
                if (req) begin
                    build(i);
                    mode[i] = 1;
                end
            end
            1: begin
                cmp(v && !a && dd == expq[i][pos[i]], "byte_stream", act, {22'b0, 2'b01, expq[i][pos[i]]});
                if (rdy) begin
                    pos[i]++;
                    if (pos[i] == len[i]) mode[i] = 2;
                end
            end
            default: begin
                cmp(!v && a, "ack_pulse", act, 32'h200);
                mode[i] = 0;
            end
        endcase
    endtask

    // compare process: outputs sampled mid-cycle, inputs stable here
    always @(negedge clk) begin
        chk(0, vld_a, ack_a, d_a);
        chk(1, vld_b, ack_b, d_b);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input bit rnd_rdy);
        int n = 0;
        while (!(mode[0] == 0 && mode[1] == 0) && n < budget) begin
            if (rnd_rdy) rdy = 1'($urandom % 2);
            step();
            n++;
        end
        rdy = 1'b1;
        cmp(mode[0] == 0 && mode[1] == 0, "idle_timeout", 32'(n), 32'(budget));
    endtask

    task automatic pin(input string name, input logic [7:0] got[$], input int base, input logic [7:0] want[$]);
        cmp(got.size() - base == want.size(), name, 32'(got.size() - base), 32'(want.size()));
        for (int k = 0; k < want.size(); k++) begin
            logic [7:0] g;
            g = (base + k < got.size()) ? got[base + k] : 8'h00;
            cmp(g == want[k], name, 32'(g), 32'(want[k]));
        end
    endtask

    task automatic pulse(input logic t, input logic [31:0] w);
        typ  = t;
        dout = w;
        req  = 1'b1;
        step();
        req  = 1'b0;
    endtask

    initial begin
        logic [7:0] wa[$];
        logic [7:0] wb[$];
        int ba, bb, aa, ab, n;

        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; pos[i] = 0; len[i] = 0; ack_cnt[i] = 0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();

        // single character
        ba = log_a.size(); bb = log_b.size(); aa = ack_cnt[0]; ab = ack_cnt[1];
        pulse(1'b0, 32'h0000_0052);
        wait_idle(20, 1'b0);
        wa = '{8'h52};
        pin("char_a", log_a, ba, wa);
        pin("char_b", log_b, bb, wa);
        cmp(ack_cnt[0] - aa == 1, "char_ack_count", 32'(ack_cnt[0] - aa), 32'd1);

        // hex word, no stalls
        ba = log_a.size(); bb = log_b.size(); aa = ack_cnt[0]; ab = ack_cnt[1];
        pulse(1'b1, 32'h1234_ABCD);
        wait_idle(30, 1'b0);
        wa = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20};
        wb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64};
        pin("hex_a", log_a, ba, wa);
        pin("hex_b", log_b, bb, wb);
        cmp(ack_cnt[0] - aa == 1, "hex_ack_count_a", 32'(ack_cnt[0] - aa), 32'd1);
        cmp(ack_cnt[1] - ab == 1, "hex_ack_count_b", 32'(ack_cnt[1] - ab), 32'd1);

        // same word with random back-pressure
        ba = log_a.size(); bb = log_b.size();
        pulse(1'b1, 32'h1234_ABCD);
        wait_idle(400, 1'b1);
        pin("stall_a", log_a, ba, wa);
        pin("stall_b", log_b, bb, wb);

        // lowercase, no separator boundary on instance b
        ba = log_a.size(); bb = log_b.size();
        pulse(1'b1, 32'h0000_000F);
        wait_idle(30, 1'b0);
        wa = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h46, 8'h20};
        wb = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h66};
        pin("nosep_a", log_a, ba, wa);
        pin("nosep_b", log_b, bb, wb);

        // reset after the third hex byte, then a fresh request
        ba = log_a.size(); aa = ack_cnt[0];
        pulse(1'b1, $urandom);
        n = 0;
        while (log_a.size() < ba + 3 && n < 20) begin step(); n++; end
        cmp(n < 20, "three_bytes_timeout", 32'(n), 32'd20);
        rst = 1'b1;
        #1;
        cmp(!vld_a && !ack_a && !vld_b && !ack_b, "reset_abort",
            {28'b0, vld_a, ack_a, vld_b, ack_b}, 32'h0);
        step(); step();
        rst = 1'b0;
        step();
        cmp(ack_cnt[0] == aa, "no_ack_after_abort", 32'(ack_cnt[0] - aa), 32'd0);
        ba = log_a.size(); bb = log_b.size();
        pulse(1'b1, 32'hFFFF_FFFF);
        wait_idle(30, 1'b0);
        wa = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h20};
        wb = '{8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66};
        pin("post_reset_a", log_a, ba, wa);
        pin("post_reset_b", log_b, bb, wb);

        // inputs change and req drops mid-word
        ba = log_a.size(); aa = ack_cnt[0];
        typ = 1'b1; dout = 32'hDEAD_BEEF; req = 1'b1;
        repeat (3) step();
        dout = 32'h1111_1111; typ = 1'b0; req = 1'b0;
        wait_idle(30, 1'b0);
        wa = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h20};
        pin("latched_word", log_a, ba, wa);
        cmp(ack_cnt[0] - aa == 1, "latched_ack", 32'(ack_cnt[0] - aa), 32'd1);

        // req held through ack starts a second transaction
        ba = log_a.size(); aa = ack_cnt[0];
        typ = 1'b0; dout = 32'h0000_0041; req = 1'b1;
        n = 0;
        while (ack_cnt[0] - aa < 2 && n < 30) begin step(); n++; end
        req = 1'b0;
        wait_idle(30, 1'b0);
        wa = '{8'h41, 8'h41};
        pin("held_req", log_a, ba, wa);
        cmp(n < 30, "held_req_acks", 32'(ack_cnt[0] - aa), 32'd2);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            req  = 1'($urandom % 4 == 0);
            typ  = 1'($urandom % 2);
            dout = $urandom;
            rdy  = 1'($urandom % 4 != 0);
            step();
        end
        req = 1'b0;
        wait_idle(100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
